// File: rtl/pic_ctl.sv
`default_nettype none
// ============================================================================
// Module   : pic_ctl
// Purpose  : Programmable interrupt controller for the I/O port bus.
//            Collects up to 16 rising-edge request lines into IRR, masks them
//            with IMR, and tracks in-service levels in ISR with fully nested
//            priority. A delivered request is presented to the CPU as a vector
//            number on irq together with the intr/intl toggle handshake.
//            Optional build macro PIC_ROTATE_EN adds rotating priority: EOI
//            commands with port_o[7]=1 also move the lowest-priority level.
// Ports    : clock, reset_n        - host clock, async active-low reset
//            port_clk/port/port_o/port_w - port bus access (strobe, address,
//                                    write data, write enable)
//            port_i, port_hit      - registered read data / access flag
//            irq_line[IRQ_N-1:0]   - rising-edge request inputs
//            intr, intl            - request / acknowledge toggles
//            irq[7:0]              - vector of the delivered request
// Register map (offsets from BASE_PORT):
//            +0 W command (EOI / read select)  R IRR[7:0] or ISR[7:0]
//            +1 RW IMR[7:0]   +2 RW IMR[15:8]   +3 RW vector base
//            +4 R IRR[15:8] or ISR[15:8]
// Revision : 1.0 - initial release
// ============================================================================
module pic_ctl #(
   parameter int          IRQ_N      = 8,
   parameter logic [15:0] BASE_PORT  = 16'h0020,
   parameter logic [7:0]  VECT_RESET = 8'h08
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             port_clk,
   input  logic [15:0]      port,
   input  logic [7:0]       port_o,
   input  logic             port_w,
   output logic [7:0]       port_i,
   output logic             port_hit,
   input  logic [IRQ_N-1:0] irq_line,
   output logic             intr,
   input  logic             intl,
   output logic [7:0]       irq
);

   localparam logic [4:0] c_N5         = 5'(IRQ_N);
   localparam logic [3:0] c_PRIO_FIXED = 4'(IRQ_N - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [IRQ_N-1:0] r_irr;
   logic [IRQ_N-1:0] r_imr;
   logic [IRQ_N-1:0] r_isr;
   logic [IRQ_N-1:0] r_irq_d;
   logic [7:0]       r_vect;
   logic             r_rsel;
   logic             r_intr;
   logic [7:0]       r_irq;
   logic [7:0]       r_port_i;
   logic             r_port_hit;

   logic [3:0]       w_prio_low;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic [15:0]      w_irr16;
   logic [15:0]      w_imr16;
   logic [15:0]      w_isr16;
   logic [15:0]      w_cand16;
   logic [4:0]       w_lvl5;
   logic             w_cand_found;
   logic [3:0]       w_cand_lvl;
   logic [4:0]       w_cand_rank;
   logic             w_top_found;
   logic [3:0]       w_top_lvl;
   logic [4:0]       w_top_rank;
   logic             w_deliver;
   logic [IRQ_N-1:0] w_dlv;
   logic [IRQ_N-1:0] w_eoi;
   logic [IRQ_N-1:0] w_imr_nxt;
   logic [15:0]      w_off;
   logic             w_acc;
   logic             w_wr;
   logic             w_rd;
   logic             w_cmd0;
   logic             w_spec_ok;
   logic [7:0]       w_rd_data;

   // Zero-padded 16-bit views so register reads and the priority scan can use
   // fixed widths regardless of IRQ_N.
   always_comb begin
      w_irr16 = '0;
      w_imr16 = '0;
      w_isr16 = '0;
      w_irr16[IRQ_N-1:0] = r_irr;
      w_imr16[IRQ_N-1:0] = r_imr;
      w_isr16[IRQ_N-1:0] = r_isr;
   end

   assign w_cand16 = w_irr16 & ~w_imr16;

   // Walk the levels in rank order (rank 0 first). The level of rank r is
   // (r + prio_low + 1) mod IRQ_N; the sum never exceeds 2*IRQ_N-1, so one
   // conditional subtraction is enough. The first hit is the winner.
   always_comb begin
      w_lvl5       = '0;
      w_cand_found = 1'b0;
      w_cand_lvl   = '0;
      w_cand_rank  = '0;
      w_top_found  = 1'b0;
      w_top_lvl    = '0;
      w_top_rank   = '0;
      for (int r = 0; r < IRQ_N; r++) begin
         w_lvl5 = 5'(r) + {1'b0, w_prio_low} + 5'd1;
         if (w_lvl5 >= c_N5) begin
            w_lvl5 = w_lvl5 - c_N5;
         end
         if (!w_cand_found && w_cand16[w_lvl5[3:0]]) begin
            w_cand_found = 1'b1;
            w_cand_lvl   = w_lvl5[3:0];
            w_cand_rank  = 5'(r);
         end
         if (!w_top_found && w_isr16[w_lvl5[3:0]]) begin
            w_top_found = 1'b1;
            w_top_lvl   = w_lvl5[3:0];
            w_top_rank  = 5'(r);
         end
      end
   end

   // Fully nested: a candidate must outrank every level already in service.
   assign w_deliver = (r_intr == intl) && w_cand_found &&
                      (!w_top_found || (w_cand_rank < w_top_rank));

   // ------------------------------------------------------------------------
   // Port decode (unsigned wrap makes addresses below BASE_PORT miss)
   // ------------------------------------------------------------------------
   assign w_off     = port - BASE_PORT;
   assign w_acc     = port_clk && (w_off < 16'd5);
   assign w_wr      = w_acc && port_w;
   assign w_rd      = w_acc && !port_w;
   assign w_cmd0    = w_wr && (w_off == 16'd0);
   assign w_spec_ok = ({1'b0, port_o[3:0]} < c_N5);

   always_comb begin
      w_dlv     = '0;
      w_eoi     = '0;
      w_imr_nxt = r_imr;
      for (int l = 0; l < IRQ_N; l++) begin
         w_dlv[l] = w_deliver && (w_cand_lvl == 4'(l));
         if (w_cmd0 && port_o[5]) begin
            if (!port_o[6]) begin
               w_eoi[l] = w_top_found && (w_top_lvl == 4'(l));
            end else begin
               w_eoi[l] = w_spec_ok && (port_o[3:0] == 4'(l));
            end
         end
         if (l < 8) begin
            if (w_wr && (w_off == 16'd1)) begin
               w_imr_nxt[l] = port_o[l % 8];
            end
         end else begin
            if (w_wr && (w_off == 16'd2)) begin
               w_imr_nxt[l] = port_o[l % 8];
            end
         end
      end
   end

   always_comb begin
      w_rd_data = 8'h00;
      case (w_off[2:0])
         3'd0:    w_rd_data = r_rsel ? w_isr16[7:0]  : w_irr16[7:0];
         3'd1:    w_rd_data = w_imr16[7:0];
         3'd2:    w_rd_data = w_imr16[15:8];
         3'd3:    w_rd_data = r_vect;
         3'd4:    w_rd_data = r_rsel ? w_isr16[15:8] : w_irr16[15:8];
         default: w_rd_data = 8'h00;
      endcase
   end

   // ------------------------------------------------------------------------
   // Priority rotation
   // ------------------------------------------------------------------------
`ifdef PIC_ROTATE_EN
   logic [3:0] r_prio_low;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_prio_low <= c_PRIO_FIXED;
      end else if (w_cmd0 && port_o[7] && port_o[5]) begin
         if (!port_o[6]) begin
            if (w_top_found) begin
               r_prio_low <= w_top_lvl;
            end
         end else if (w_spec_ok) begin
            r_prio_low <= port_o[3:0];
         end
      end
   end

   assign w_prio_low = r_prio_low;
`else
   assign w_prio_low = c_PRIO_FIXED;
`endif

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_irr      <= '0;
         r_imr      <= '0;
         r_isr      <= '0;
         r_irq_d    <= '0;
         r_vect     <= VECT_RESET;
         r_rsel     <= 1'b0;
         r_intr     <= 1'b0;
         r_irq      <= 8'h00;
         r_port_i   <= 8'h00;
         r_port_hit <= 1'b0;
      end else begin
         r_irq_d    <= irq_line;
         // A fresh edge on the level being delivered keeps IRR set.
         r_irr      <= (r_irr & ~w_dlv) | (irq_line & ~r_irq_d);
         r_isr      <= (r_isr & ~w_eoi) | w_dlv;
         r_imr      <= w_imr_nxt;
         r_port_hit <= w_acc;
         if (w_deliver) begin
            r_irq  <= r_vect + {4'b0000, w_cand_lvl};
            r_intr <= ~intl;
         end
         if (w_wr && (w_off == 16'd3)) begin
            r_vect <= port_o;
         end
         if (w_cmd0 && !port_o[5] && (port_o[4:3] == 2'b01)) begin
            r_rsel <= port_o[0];
         end
         if (w_rd) begin
            r_port_i <= w_rd_data;
         end
      end
   end

   assign intr     = r_intr;
   assign irq      = r_irq;
   assign port_i   = r_port_i;
   assign port_hit = r_port_hit;

endmodule
`default_nettype wire

// File: tb/tb_pic_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_ctl
// Purpose  : Self-checking bench for pic_ctl. A behavioural model keeps the
//            controller state as plain bitmasks and picks winners by computing
//            each level's rank with modular arithmetic; directed scenarios are
//            followed by a long randomized run with occasional resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_ctl;

   localparam int          N    = 8;
   localparam logic [15:0] BASE = 16'h0020;

   logic         clock    = 1'b0;
   logic         reset_n  = 1'b0;
   logic         port_clk = 1'b0;
   logic [15:0]  port     = 16'h0000;
   logic [7:0]   port_o   = 8'h00;
   logic         port_w   = 1'b0;
   logic [7:0]   port_i;
   logic         port_hit;
   logic [N-1:0] irq_line = '0;
   logic         intr;
   logic         intl     = 1'b0;
   logic [7:0]   irq;

   pic_ctl #(
      .IRQ_N      (N),
      .BASE_PORT  (BASE),
      .VECT_RESET (8'h08)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .port_clk (port_clk),
      .port     (port),
      .port_o   (port_o),
      .port_w   (port_w),
      .port_i   (port_i),
      .port_hit (port_hit),
      .irq_line (irq_line),
      .intr     (intr),
      .intl     (intl),
      .irq      (irq)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model state ----------------
   logic [N-1:0] m_irr, m_imr, m_isr, m_irq_d;
   logic [7:0]   m_vect, m_irq, m_port_i;
   logic         m_rsel, m_intr, m_port_hit;
   int           m_prio;

   task automatic check_val(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int rank(input int l);
      return (((l - m_prio - 1) % N) + N) % N;
   endfunction

   task automatic model_reset();
      m_irr = '0; m_imr = '0; m_isr = '0; m_irq_d = '0;
      m_vect = 8'h08; m_irq = 8'h00; m_port_i = 8'h00;
      m_rsel = 1'b0; m_intr = 1'b0; m_port_hit = 1'b0;
      m_prio = N - 1;
   endtask

   task automatic check_outputs(input string where);
      check_val({where, ".intr"},     32'(intr),     32'(m_intr));
      check_val({where, ".irq"},      32'(irq),      32'(m_irq));
      check_val({where, ".port_i"},   32'(port_i),   32'(m_port_i));
      check_val({where, ".port_hit"}, 32'(port_hit), 32'(m_port_hit));
   endtask

   // One clock: evaluate the model on the inputs present at the edge, then
   // compare all outputs just after the edge.
   task automatic tick();
      int           best, top, off, lvl, prio_n;
      bit           dlv, acc;
      logic [N-1:0] irr_n, isr_n, imr_n, eoi, dmask;
      logic [15:0]  irr16, isr16, imr16;
      logic [7:0]   vect_n, irq_n, pi_n;
      logic         rsel_n, intr_n;

      best = -1; top = -1;
      for (int l = 0; l < N; l++) begin
         if (m_irr[l] && !m_imr[l] && (best < 0 || rank(l) < rank(best))) best = l;
         if (m_isr[l] && (top < 0 || rank(l) < rank(top))) top = l;
      end
      dlv = (m_intr == intl) && (best >= 0) && (top < 0 || rank(best) < rank(top));
      off = int'(port) - int'(BASE);
      acc = port_clk && (off >= 0) && (off <= 4);

      dmask = '0;
      eoi   = '0;
      irq_n = m_irq; intr_n = m_intr;
      if (dlv) begin
         dmask[best] = 1'b1;
         irq_n  = 8'((int'(m_vect) + best) % 256);
         intr_n = ~intl;
      end

      irr16 = 16'(m_irr); isr16 = 16'(m_isr); imr16 = 16'(m_imr);
      vect_n = m_vect; rsel_n = m_rsel; prio_n = m_prio; pi_n = m_port_i;
      if (acc && port_w) begin
         case (off)
            0: begin
               if (port_o[5]) begin
                  if (!port_o[6]) begin
                     lvl = top;
                  end else begin
                     lvl = int'(port_o[3:0]);
                     if (lvl >= N) lvl = -1;
                  end
                  if (lvl >= 0) begin
                     eoi[lvl] = 1'b1;
`ifdef PIC_ROTATE_EN
                     if (port_o[7]) prio_n = lvl;
`endif
                  end
               end else if (port_o[4:3] == 2'b01) begin
                  rsel_n = port_o[0];
               end
            end
            1: imr16[7:0]  = port_o;
            2: imr16[15:8] = port_o;
            3: vect_n      = port_o;
            default: ;
         endcase
      end else if (acc) begin
         case (off)
            0: pi_n = m_rsel ? isr16[7:0]  : irr16[7:0];
            1: pi_n = imr16[7:0];
            2: pi_n = imr16[15:8];
            3: pi_n = m_vect;
            4: pi_n = m_rsel ? isr16[15:8] : irr16[15:8];
            default: ;
         endcase
      end
      imr_n = imr16[N-1:0];
      irr_n = (m_irr & ~dmask) | (irq_line & ~m_irq_d);
      isr_n = (m_isr & ~eoi) | dmask;

      @(posedge clock);
      m_irq_d = irq_line;
      m_irr = irr_n; m_isr = isr_n; m_imr = imr_n;
      m_vect = vect_n; m_rsel = rsel_n; m_prio = prio_n;
      m_irq = irq_n; m_intr = intr_n; m_port_i = pi_n; m_port_hit = acc;
      #1;
      check_outputs("cyc");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(input logic [N-1:0] m);
      irq_line = m; tick();
      irq_line = '0; tick();
   endtask

   task automatic wr(input int off, input logic [7:0] d);
      port_clk = 1'b1; port_w = 1'b1; port = BASE + 16'(off); port_o = d;
      tick();
      port_clk = 1'b0; port_w = 1'b0;
   endtask

   task automatic rd(input int off, output logic [7:0] v);
      port_clk = 1'b1; port_w = 1'b0; port = BASE + 16'(off);
      tick();
      port_clk = 1'b0;
      v = port_i;
   endtask

   task automatic ack();
      intl = m_intr;
      tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      intl = 1'b0;
      check_outputs("rst");
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   logic [7:0] v;

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_outputs("reset");
      reset_n = 1'b1;

      // Single request on line 1
      pulse(8'h02);
      check_val("line1.irq", 32'(irq), 32'h09);
      check_val("line1.pending", 32'(intr != intl), 32'h1);
      wr(0, 8'h0B);
      rd(0, v);
      check_val("line1.isr", 32'(v), 32'h02);
      wr(0, 8'h0A);
      rd(0, v);
      check_val("line1.irr", 32'(v), 32'h00);

      // Lines 3 and 5 together
      ack(); wr(0, 8'h20);
      pulse(8'h28); idle(1);
      check_val("pair.first", 32'(irq), 32'h0B);
      ack(); wr(0, 8'h20); idle(2);
      check_val("pair.second", 32'(irq), 32'h0D);
      ack(); wr(0, 8'h20); idle(1);

      // Nesting: 4 in service, 2 preempts, 6 waits
      pulse(8'h10);
      check_val("nest.l4", 32'(irq), 32'h0C);
      ack();
      pulse(8'h04);
      check_val("nest.l2", 32'(irq), 32'h0A);
      ack();
      pulse(8'h40); idle(2);
      check_val("nest.l6_held", 32'(intr), 32'(intl));
      rd(0, v);
      check_val("nest.irr", 32'(v), 32'h40);
      wr(0, 8'h20); idle(2);
      check_val("nest.l6_still", 32'(intr), 32'(intl));
      wr(0, 8'h20); idle(2);
      check_val("nest.l6", 32'(irq), 32'h0E);
      ack(); wr(0, 8'h20); idle(1);

      // Masked request stays pending
      wr(1, 8'h01);
      pulse(8'h01); idle(2);
      check_val("mask.held", 32'(intr), 32'(intl));
      rd(0, v);
      check_val("mask.irr", 32'(v), 32'h01);
      wr(1, 8'h00); idle(1);
      check_val("mask.release", 32'(irq), 32'h08);
      ack(); wr(0, 8'h20);

      // Vector wrap
      wr(3, 8'hF8);
      pulse(8'h80);
      check_val("wrap.irq", 32'(irq), 32'hFF);
      ack(); wr(0, 8'h20); wr(3, 8'h08); idle(1);

`ifdef PIC_ROTATE_EN
      pulse(8'h01);
      check_val("rot.l0", 32'(irq), 32'h08);
      ack(); wr(0, 8'hA0);
      wr(1, 8'h03);
      pulse(8'h03);
      wr(1, 8'h00); idle(1);
      check_val("rot.first", 32'(irq), 32'h09);
      ack(); wr(0, 8'h20); idle(2);
      check_val("rot.second", 32'(irq), 32'h08);
      ack(); wr(0, 8'h20); wr(0, 8'hE7); idle(1);
`endif

      // Reset with a request outstanding
      pulse(8'h08);
      do_reset();
      idle(2);

      // Randomized traffic
      for (int c = 0; c < 6000; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 9) == 0) irq_line[b] = ~irq_line[b];
         end
         if (m_intr != intl && $urandom_range(0, 2) == 0) intl = m_intr;
         port_clk = 1'b0; port_w = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            port_clk = 1'b1;
            port_w   = 1'($urandom_range(0, 1));
            port     = BASE + 16'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) port = BASE - 16'd1;
            case ($urandom_range(0, 5))
               0: port_o = 8'h20;
               1: port_o = 8'h60 | 8'($urandom_range(0, 15));
               2: port_o = 8'h08 | 8'($urandom_range(0, 1));
               3: port_o = 8'($urandom);
               4: port_o = 8'($urandom & $urandom & $urandom);
               default: port_o = 8'hA0 | 8'($urandom_range(0, 1) << 6);
            endcase
         end
         if ($urandom_range(0, 999) == 0) do_reset();
         else tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
